// File: rtl/urv_imem_bridge.sv
// Instruction-memory responder for the fetch stage.
// A single prefetch line of LINE_WORDS words serves hits one cycle after the
// address is sampled; misses fill the whole line, word 0 first, from a simple
// req/ack word bus. Fills always run to completion, even if fetch branches away.
module urv_imem_bridge #(
    parameter int LINE_WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic        inv_i,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_data_i
);

    localparam int LW_BITS = $clog2(LINE_WORDS);
    localparam int TAG_W   = 30 - LW_BITS;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state_reg, state_next;

    logic [31:2]        addr_reg;
    logic [TAG_W-1:0]   addr_tag;
    logic [TAG_W-1:0]   line_tag_reg;
    logic [TAG_W-1:0]   fill_tag_reg;
    logic               line_valid_reg;
    logic               inv_pending_reg;
    logic [LW_BITS-1:0] cnt_reg;
    logic [LW_BITS-1:0] word_sel;
    logic [31:0]        line_mem [LINE_WORDS];
    logic               hit;
    logic               fill_ack;
    logic               last_ack;

    // Byte-offset bits of the fetch address carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^im_addr_i[1:0];

    assign addr_tag   = addr_reg[31:LW_BITS+2];
    assign word_sel   = addr_reg[LW_BITS+1:2];
    assign hit        = line_valid_reg && (line_tag_reg == addr_tag);
    assign im_valid_o = hit;
    assign im_data_o  = hit ? line_mem[word_sel] : 32'd0;

    // An ack only counts while a request is actually outstanding.
    assign fill_ack = (state_reg == FILL) && bus_req_o && bus_ack_i;
    assign last_ack = fill_ack && (cnt_reg == LW_BITS'(LINE_WORDS - 1));

    // Next-state: start a fill on any miss, return to IDLE on the last word.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!hit) state_next = FILL;
            FILL:    if (last_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Fetch address is captured every edge; a stalled fetch simply re-presents it.
    always_ff @(posedge clk_i) begin
        if (rst_i) addr_reg <= '0;
        else       addr_reg <= im_addr_i[31:2];
    end

    // Line bookkeeping and bus request generation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_valid_reg  <= 1'b0;
            inv_pending_reg <= 1'b0;
            line_tag_reg    <= '0;
            fill_tag_reg    <= '0;
            cnt_reg         <= '0;
            bus_req_o       <= 1'b0;
            bus_addr_o      <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (inv_i) line_valid_reg <= 1'b0;
                    if (!hit) begin
                        fill_tag_reg   <= addr_tag;
                        line_valid_reg <= 1'b0;
                        cnt_reg        <= '0;
                        bus_req_o      <= 1'b1;
                        bus_addr_o     <= {addr_tag, {LW_BITS{1'b0}}, 2'b00};
                    end
                end
                FILL: begin
                    // An invalidate landing mid-fill poisons the line being filled.
                    if (inv_i && !last_ack) inv_pending_reg <= 1'b1;
                    if (fill_ack) begin
                        cnt_reg <= cnt_reg + LW_BITS'(1);
                        if (last_ack) begin
                            bus_req_o       <= 1'b0;
                            line_tag_reg    <= fill_tag_reg;
                            line_valid_reg  <= !inv_pending_reg && !inv_i;
                            inv_pending_reg <= 1'b0;
                        end else begin
                            bus_addr_o <= bus_addr_o + 32'd4;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage: each accepted bus word lands at the current fill index.
    always_ff @(posedge clk_i) begin
        if (!rst_i && fill_ack) line_mem[cnt_reg] <= bus_data_i;
    end

endmodule

// File: tb/tb_urv_imem_bridge.sv
// Bench for urv_imem_bridge: directed scenarios plus a randomized run, all
// checked against a line-buffer model kept in terms of line base addresses.
module tb_urv_imem_bridge;

    localparam int LW = 4;
    localparam logic [31:0] XORK = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'd0;
    logic        inv = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] bdata = 32'd0;
    logic [31:0] im_data;
    logic        im_valid;
    logic        bus_req;
    logic [31:0] bus_addr;

    always #5 clk = ~clk;

    urv_imem_bridge #(.LINE_WORDS(LW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .im_addr_i  (addr),
        .im_data_o  (im_data),
        .im_valid_o (im_valid),
        .inv_i      (inv),
        .bus_req_o  (bus_req),
        .bus_addr_o (bus_addr),
        .bus_ack_i  (ack),
        .bus_data_i (bdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Bus responder configuration
    int          ws = 0;
    int          wcnt = 0;
    bit          rnd_bus = 0;
    bit          force_ack = 0;
    bit          acc = 0;
    logic [31:0] acc_addr = 32'd0;

    // Reference model: one line identified by its base address
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_line [LW];
    logic [31:0] m_base = 32'd0;
    logic [31:0] m_fbase = 32'd0;
    logic [31:0] m_baddr = 32'd0;
    bit          m_lvalid = 0;
    bit          m_filling = 0;
    bit          m_invp = 0;
    int          m_idx = 0;

    function automatic logic [31:0] base_of(logic [31:0] a);
        return a & ~32'(LW * 4 - 1);
    endfunction

    function automatic bit m_hit();
        return m_lvalid && (base_of(m_addr) == m_base);
    endfunction

    function automatic logic [31:0] m_data();
        if (!m_hit()) return 32'd0;
        return m_line[int'((m_addr - m_base) >> 2)];
    endfunction

    // Apply one clock edge worth of the line-buffer rules to the model.
    task automatic model_step();
        bit h;
        bit last;
        h = m_hit();
        if (rst) begin
            m_addr = 0; m_lvalid = 0; m_filling = 0; m_invp = 0;
            m_baddr = 0; m_base = 0; m_idx = 0;
        end else begin
            if (!m_filling) begin
                if (inv) m_lvalid = 0;
                if (!h) begin
                    m_fbase = base_of(m_addr);
                    m_lvalid = 0;
                    m_idx = 0;
                    m_filling = 1;
                    m_baddr = m_fbase;
                end
            end else begin
                last = ack && (m_idx == LW - 1);
                if (inv && !last) m_invp = 1;
                if (ack) begin
                    m_line[m_idx] = bdata;
                    if (last) begin
                        m_filling = 0;
                        m_base = m_fbase;
                        m_lvalid = !m_invp && !inv;
                        m_invp = 0;
                    end else begin
                        m_idx++;
                        m_baddr = m_fbase + 32'(4 * m_idx);
                    end
                end
            end
            m_addr = addr;
        end
    endtask

    // One clock: bus responder decides ack, edge, model update, settle.
    task automatic cyc();
        int next_w;
        if (rnd_bus) begin
            ack = 1'($urandom_range(0, 1));
            bdata = $urandom;
        end else begin
            ack = force_ack || (bus_req && wcnt == ws);
            bdata = bus_addr ^ XORK;
        end
        next_w = ack ? 0 : (bus_req ? wcnt + 1 : 0);
        acc = ack && bus_req && !rst;
        acc_addr = bus_addr;
        if (acc) $display("bus word addr=%h data=%h", bus_addr, bdata);
        @(posedge clk);
        model_step();
        wcnt = next_w;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; addr = 32'h100; inv = 0;
        repeat (2) begin
            cyc();
            n_checks++;
            if ({im_valid, im_data, bus_req, bus_addr} !== 66'd0)
                $display("FAIL reset_outputs got v=%b d=%h req=%b a=%h want all zero",
                         im_valid, im_data, bus_req, bus_addr);
            else n_pass++;
        end
        rst = 0; addr = 32'h0;
        for (int c = 0; c < 20 && !m_hit(); c++) begin
            cyc();
            n_checks++;
            if ({im_valid, im_data, bus_req, bus_addr} !== {m_hit(), m_data(), m_filling, m_baddr})
                $display("FAIL warm_model got v=%b d=%h req=%b a=%h want v=%b d=%h req=%b a=%h",
                         im_valid, im_data, bus_req, bus_addr, m_hit(), m_data(), m_filling, m_baddr);
            else n_pass++;
        end
        n_checks++;
        if (im_valid !== 1'b1) $display("FAIL warm_fill_valid got %b want 1", im_valid);
        else n_pass++;
    endtask

    task automatic test_miss_fill();
        addr = 32'h100;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            n_checks++;
            if ({im_valid, im_data, bus_req, bus_addr} !== {m_hit(), m_data(), m_filling, m_baddr})
                $display("FAIL miss_model c=%0d got v=%b d=%h req=%b a=%h want v=%b d=%h req=%b a=%h",
                         c, im_valid, im_data, bus_req, bus_addr, m_hit(), m_data(), m_filling, m_baddr);
            else n_pass++;
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if ({bus_req, bus_addr} !== {1'b1, 32'h100 + 32'(4 * (c - 2))})
                    $display("FAIL miss_bus_addr c=%0d got req=%b a=%h want req=1 a=%h",
                             c, bus_req, bus_addr, 32'h100 + 32'(4 * (c - 2)));
                else n_pass++;
            end
            n_checks++;
            if (im_valid !== (c >= 6))
                $display("FAIL miss_valid c=%0d got %b want %b", c, im_valid, c >= 6);
            else n_pass++;
            if (c == 6) begin
                n_checks++;
                if (im_data !== 32'hA5A5A4A5)
                    $display("FAIL miss_first_data got %h want a5a5a4a5", im_data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hits();
        logic [31:0] seq [4];
        seq[0] = 32'h104; seq[1] = 32'h108; seq[2] = 32'h10C; seq[3] = 32'h100;
        for (int i = 0; i < 4; i++) begin
            addr = seq[i];
            cyc();
            n_checks++;
            if ({im_valid, im_data, bus_req} !== {1'b1, seq[i] ^ XORK, 1'b0})
                $display("FAIL hit_word a=%h got v=%b d=%h req=%b want v=1 d=%h req=0",
                         seq[i], im_valid, im_data, bus_req, seq[i] ^ XORK);
            else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        ws = 2; addr = 32'h200;
        for (int c = 1; c <= 15; c++) begin
            cyc();
            n_checks++;
            if ({im_valid, im_data, bus_req, bus_addr} !== {m_hit(), m_data(), m_filling, m_baddr})
                $display("FAIL ws_model c=%0d got v=%b d=%h req=%b a=%h want v=%b d=%h req=%b a=%h",
                         c, im_valid, im_data, bus_req, bus_addr, m_hit(), m_data(), m_filling, m_baddr);
            else n_pass++;
            if (c >= 2 && c <= 13) begin
                n_checks++;
                if ({bus_req, bus_addr} !== {1'b1, 32'h200 + 32'(4 * ((c - 2) / 3))})
                    $display("FAIL ws_bus_addr c=%0d got req=%b a=%h want req=1 a=%h",
                             c, bus_req, bus_addr, 32'h200 + 32'(4 * ((c - 2) / 3)));
                else n_pass++;
            end
            n_checks++;
            if (im_valid !== (c >= 14))
                $display("FAIL ws_valid c=%0d got %b want %b", c, im_valid, c >= 14);
            else n_pass++;
        end
        ws = 0;
    endtask

    task automatic test_branch();
        addr = 32'h300;
        for (int c = 1; c <= 12; c++) begin
            if (c == 4) addr = 32'h400;
            cyc();
            n_checks++;
            if ({im_valid, im_data, bus_req, bus_addr} !== {m_hit(), m_data(), m_filling, m_baddr})
                $display("FAIL branch_model c=%0d got v=%b d=%h req=%b a=%h want v=%b d=%h req=%b a=%h",
                         c, im_valid, im_data, bus_req, bus_addr, m_hit(), m_data(), m_filling, m_baddr);
            else n_pass++;
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if (bus_addr !== 32'h300 + 32'(4 * (c - 2)))
                    $display("FAIL branch_old_line c=%0d got %h want %h", c, bus_addr, 32'h300 + 32'(4 * (c - 2)));
                else n_pass++;
            end
            if (c >= 7 && c <= 10) begin
                n_checks++;
                if ({bus_req, bus_addr} !== {1'b1, 32'h400 + 32'(4 * (c - 7))})
                    $display("FAIL branch_new_line c=%0d got req=%b a=%h want req=1 a=%h",
                             c, bus_req, bus_addr, 32'h400 + 32'(4 * (c - 7)));
                else n_pass++;
            end
            n_checks++;
            if (im_valid !== (c >= 11))
                $display("FAIL branch_valid c=%0d got %b want %b", c, im_valid, c >= 11);
            else n_pass++;
        end
    endtask

    task automatic test_invalidate();
        addr = 32'h500;
        for (int c = 1; c <= 12; c++) begin
            inv = (c == 4);
            cyc();
            n_checks++;
            if ({im_valid, im_data, bus_req, bus_addr} !== {m_hit(), m_data(), m_filling, m_baddr})
                $display("FAIL inv_model c=%0d got v=%b d=%h req=%b a=%h want v=%b d=%h req=%b a=%h",
                         c, im_valid, im_data, bus_req, bus_addr, m_hit(), m_data(), m_filling, m_baddr);
            else n_pass++;
            if (c == 7) begin
                n_checks++;
                if ({bus_req, bus_addr} !== {1'b1, 32'h500})
                    $display("FAIL inv_refill_start got req=%b a=%h want req=1 a=00000500", bus_req, bus_addr);
                else n_pass++;
            end
            n_checks++;
            if (im_valid !== (c >= 11))
                $display("FAIL inv_fill_valid c=%0d got %b want %b", c, im_valid, c >= 11);
            else n_pass++;
        end
        inv = 0; addr = 32'h504;
        cyc();
        n_checks++;
        if ({im_valid, im_data} !== {1'b1, 32'h504 ^ XORK})
            $display("FAIL inv_pre_hit got v=%b d=%h want v=1 d=%h", im_valid, im_data, 32'h504 ^ XORK);
        else n_pass++;
        inv = 1;
        cyc();
        inv = 0;
        n_checks++;
        if (im_valid !== 1'b0) $display("FAIL inv_idle_clears got %b want 0", im_valid);
        else n_pass++;
        for (int c = 0; c < 12 && !m_hit(); c++) begin
            cyc();
            n_checks++;
            if ({im_valid, im_data, bus_req, bus_addr} !== {m_hit(), m_data(), m_filling, m_baddr})
                $display("FAIL inv2_model got v=%b d=%h req=%b a=%h want v=%b d=%h req=%b a=%h",
                         im_valid, im_data, bus_req, bus_addr, m_hit(), m_data(), m_filling, m_baddr);
            else n_pass++;
        end
        n_checks++;
        if ({im_valid, im_data} !== {1'b1, 32'h504 ^ XORK})
            $display("FAIL inv_refill_hit got v=%b d=%h want v=1 d=%h", im_valid, im_data, 32'h504 ^ XORK);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fill();
        int n600;
        bit order_ok;
        addr = 32'h600;
        repeat (4) cyc();
        rst = 1; force_ack = 1;
        cyc();
        rst = 0;
        n_checks++;
        if (bus_req !== 1'b0) $display("FAIL rst_drops_req got %b want 0", bus_req);
        else n_pass++;
        cyc();
        force_ack = 0;
        n_checks++;
        if ({im_valid, im_data, bus_req, bus_addr} !== {m_hit(), m_data(), m_filling, m_baddr})
            $display("FAIL rst_stray_ack got v=%b d=%h req=%b a=%h want v=%b d=%h req=%b a=%h",
                     im_valid, im_data, bus_req, bus_addr, m_hit(), m_data(), m_filling, m_baddr);
        else n_pass++;
        n600 = 0; order_ok = 1;
        for (int c = 0; c < 40 && !(m_hit() && base_of(m_addr) == 32'h600); c++) begin
            cyc();
            if (acc && base_of(acc_addr) == 32'h600) begin
                if (acc_addr !== 32'h600 + 32'(4 * n600)) order_ok = 0;
                n600++;
            end
            n_checks++;
            if ({im_valid, im_data, bus_req, bus_addr} !== {m_hit(), m_data(), m_filling, m_baddr})
                $display("FAIL rst_model got v=%b d=%h req=%b a=%h want v=%b d=%h req=%b a=%h",
                         im_valid, im_data, bus_req, bus_addr, m_hit(), m_data(), m_filling, m_baddr);
            else n_pass++;
        end
        n_checks++;
        if ({n600 == 4, order_ok, im_valid} !== 3'b111)
            $display("FAIL rst_refill got words=%0d in_order=%b v=%b want words=4 in_order=1 v=1",
                     n600, order_ok, im_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] bases [3];
        bases[0] = 32'h0000_0000; bases[1] = 32'h0000_0040; bases[2] = 32'hFFFF_FFF0;
        rnd_bus = 1;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            inv = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0)
                addr = bases[$urandom_range(0, 2)] + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            cyc();
            n_checks++;
            if ({im_valid, im_data, bus_req, bus_addr} !== {m_hit(), m_data(), m_filling, m_baddr})
                $display("FAIL rand_model i=%0d got v=%b d=%h req=%b a=%h want v=%b d=%h req=%b a=%h",
                         i, im_valid, im_data, bus_req, bus_addr, m_hit(), m_data(), m_filling, m_baddr);
            else n_pass++;
        end
        rst = 0; inv = 0; rnd_bus = 0;
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hits();
        test_wait_states();
        test_branch();
        test_invalidate();
        test_reset_mid_fill();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
